// File: rtl/wrr_arbiter.sv
// Weighted round-robin arbiter: a granted requester keeps the shared resource
// for up to its weight in accepted beats, then ownership rotates onward.
module wrr_arbiter #(
   parameter int N  = 4,
   parameter int WW = 4,
   parameter int IW = $clog2(N)
) (
   input  logic            clk,
   input  logic            reset,
   input  logic [N-1:0]    req_i,
   input  logic            ready_i,
   input  logic [N*WW-1:0] weight_i,
   output logic [N-1:0]    gnt_o,
   output logic            gnt_valid_o,
   output logic [IW-1:0]   gnt_idx_o,
   output logic            beat_o,
   output logic [WW-1:0]   credit_o
);

   typedef enum logic {IDLE, GRANT} state_t;

   state_t          state, state_next;
   logic [IW-1:0]   ptr, ptr_next;
   logic [IW-1:0]   idx, idx_next;
   logic [WW-1:0]   credit, credit_next;
   logic [N-1:0]    gnt, gnt_next;

   logic [WW-1:0]   weights [N];
   logic [IW-1:0]   idx_inc;
   logic [IW-1:0]   search_start;
   logic [IW-1:0]   win_idx;
   logic            win_found;
   logic [WW-1:0]   load_credit;
   logic            held;
   logic            beat;
   logic            release_now;

   always_comb begin
      for (int k = 0; k < N; k++) begin
         weights[k] = weight_i[k*WW +: WW];
      end
   end

   // Successor of the current owner; it becomes the new search origin on release.
   always_comb begin
      logic [IW:0] inc;
      inc = {1'b0, idx} + {{IW{1'b0}}, 1'b1};
      if (inc >= (IW+1)'(N)) begin
         idx_inc = '0;
      end else begin
         idx_inc = inc[IW-1:0];
      end
   end

   assign search_start = (state == GRANT) ? idx_inc : ptr;

   // First active request at or after search_start, wrapping around.
   always_comb begin
      logic [IW:0] cand;
      win_found = 1'b0;
      win_idx   = '0;
      cand      = '0;
      for (int off = 0; off < N; off++) begin
         cand = {1'b0, search_start} + (IW+1)'(off);
         if (cand >= (IW+1)'(N)) begin
            cand = cand - (IW+1)'(N);
         end
         if (!win_found && req_i[cand[IW-1:0]]) begin
            win_found = 1'b1;
            win_idx   = cand[IW-1:0];
         end
      end
   end

   assign load_credit = (weights[win_idx] == '0) ? WW'(1) : weights[win_idx];

   assign held        = req_i[idx];
   assign beat        = (state == GRANT) && held && ready_i;
   assign release_now = !held || (beat && credit == WW'(1));

   always_ff @(posedge clk) begin
      if (reset) begin
         state  <= IDLE;
         ptr    <= '0;
         idx    <= '0;
         credit <= '0;
         gnt    <= '0;
      end else begin
         state  <= state_next;
         ptr    <= ptr_next;
         idx    <= idx_next;
         credit <= credit_next;
         gnt    <= gnt_next;
      end
   end

   // Release and re-arbitration share one edge, so back-to-back owners see no bubble.
   always_comb begin
      state_next  = state;
      ptr_next    = ptr;
      idx_next    = idx;
      credit_next = credit;
      gnt_next    = gnt;
      case (state)
         IDLE: begin
            if (win_found) begin
               state_next        = GRANT;
               idx_next          = win_idx;
               credit_next       = load_credit;
               gnt_next          = '0;
               gnt_next[win_idx] = 1'b1;
            end
         end
         GRANT: begin
            if (release_now) begin
               ptr_next = idx_inc;
               if (win_found) begin
                  idx_next          = win_idx;
                  credit_next       = load_credit;
                  gnt_next          = '0;
                  gnt_next[win_idx] = 1'b1;
               end else begin
                  state_next  = IDLE;
                  credit_next = '0;
                  gnt_next    = '0;
               end
            end else if (beat) begin
               credit_next = credit - WW'(1);
            end
         end
         default: begin
            state_next  = IDLE;
            credit_next = '0;
            gnt_next    = '0;
         end
      endcase
   end

   always_comb begin
      gnt_o       = gnt;
      gnt_valid_o = (state == GRANT);
      gnt_idx_o   = idx;
      credit_o    = credit;
      beat_o      = gnt_valid_o & ready_i;
   end

endmodule
